id_stage: RTL

- Instruction-decode stage of the 16-bit LC-3-style pipeline. Sits directly upstream of the execute stage.
- Accepts a fetched instruction and its PC from fetch over a valid/ready handshake.
- Decodes it into the execute-stage bundle: type code, SR1, SR2, DR, sign-extended imm, n/z/p condition bits and IP.
- Holds it in a one-entry pipeline register and stalls on read-after-write hazards, tracked by a register busy scoreboard.

---
 rtl/lc3_pkg.sv | 49 ++++
 rtl/id_stage_if.sv | 36 +++
 rtl/id_stage_inst_decoder.sv | 85 ++++++++
 rtl/id_stage.sv | 80 ++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 pipeline definitions: widths, opcodes, operation classes and the decoded bundle.
package lc3_pkg;

  localparam int XLEN = 16;
  localparam int NREG = 8;

  typedef logic [2:0] reg_t;
  typedef logic [4:0] type_t;

  localparam type_t TYPE_NOP    = 5'b00000;
  localparam type_t TYPE_NOT    = 5'b00100;
  localparam type_t TYPE_LEA    = 5'b00101;
  localparam type_t TYPE_ALU_RR = 5'b00110;
  localparam type_t TYPE_ALU_RI = 5'b00111;
  localparam type_t TYPE_BR     = 5'b01001;
  localparam type_t TYPE_MEM    = 5'b10001;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef struct packed {
    type_t             op_type;
    reg_t              sr1;
    reg_t              sr2;
    reg_t              dr;
    logic [XLEN-1:0]   imm;
    logic              n;
    logic              z;
    logic              p;
    logic              writes_dr;
    logic              uses_sr1;
    logic              uses_sr2;
  } decoded_t;

  // Sign-extend the low 'width' bits of raw; higher bits of raw are discarded.
  function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] raw, input logic [3:0] width);
    logic [XLEN-1:0] mask;
    mask = {XLEN{1'b1}} << width;
    return raw[width - 4'd1] ? (raw | mask) : (raw & ~mask);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch/writeback/execute-side signals of the decode stage, bundled for port connection.
interface id_stage_if;
  import lc3_pkg::*;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;
  logic            flush;
  logic            wb_valid;
  reg_t            wb_dr;
  logic            id_valid;
  logic            ex_ready;
  logic [XLEN-1:0] inst;
  type_t           op_type;
  reg_t            SR1;
  reg_t            SR2;
  reg_t            DR;
  logic [XLEN-1:0] imm;
  logic            n;
  logic            z;
  logic            p;
  logic [XLEN-1:0] IP;

  // Environment side: fetch, writeback and execute stages.
  modport master (
    output if_valid, if_inst, if_pc, flush, wb_valid, wb_dr, ex_ready,
    input  if_ready, id_valid, inst, op_type, SR1, SR2, DR, imm, n, z, p, IP
  );

  modport slave (
    input  if_valid, if_inst, if_pc, flush, wb_valid, wb_dr, ex_ready,
    output if_ready, id_valid, inst, op_type, SR1, SR2, DR, imm, n, z, p, IP
  );

endinterface

// File: rtl/id_stage_inst_decoder.sv
// Purely combinational LC-3 instruction decoder, shared with later pipeline stages.
module inst_decoder
  import lc3_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output decoded_t        dec
);

  logic [3:0] opcode;

  assign opcode = inst[15:12];

  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADD, OP_AND: begin
        dec.sr1       = inst[8:6];
        dec.dr        = inst[11:9];
        dec.uses_sr1  = 1'b1;
        dec.writes_dr = 1'b1;
        if (inst[5]) begin
          dec.op_type = TYPE_ALU_RI;
          dec.imm     = sext(inst, 4'd5);
        end else begin
          dec.op_type  = TYPE_ALU_RR;
          dec.sr2      = inst[2:0];
          dec.uses_sr2 = 1'b1;
        end
      end
      OP_NOT: begin
        dec.op_type   = TYPE_NOT;
        dec.sr1       = inst[8:6];
        dec.dr        = inst[11:9];
        dec.uses_sr1  = 1'b1;
        dec.writes_dr = 1'b1;
      end
      OP_LEA: begin
        dec.op_type   = TYPE_LEA;
        dec.dr        = inst[11:9];
        dec.imm       = sext(inst, 4'd9);
        dec.writes_dr = 1'b1;
      end
      // An all-zero word shares the BR opcode but is treated as a NOP.
      OP_BR: begin
        if (inst != '0) begin
          dec.op_type = TYPE_BR;
          dec.n       = inst[11];
          dec.z       = inst[10];
          dec.p       = inst[9];
          dec.imm     = sext(inst, 4'd9);
        end
      end
      OP_LD: begin
        dec.op_type   = TYPE_MEM;
        dec.dr        = inst[11:9];
        dec.imm       = sext(inst, 4'd9);
        dec.writes_dr = 1'b1;
      end
      OP_ST: begin
        dec.op_type  = TYPE_MEM;
        dec.sr2      = inst[11:9];
        dec.uses_sr2 = 1'b1;
        dec.imm      = sext(inst, 4'd9);
      end
      OP_LDR: begin
        dec.op_type   = TYPE_MEM;
        dec.sr1       = inst[8:6];
        dec.dr        = inst[11:9];
        dec.uses_sr1  = 1'b1;
        dec.writes_dr = 1'b1;
        dec.imm       = sext(inst, 4'd6);
      end
      OP_STR: begin
        dec.op_type  = TYPE_MEM;
        dec.sr1      = inst[8:6];
        dec.sr2      = inst[11:9];
        dec.uses_sr1 = 1'b1;
        dec.uses_sr2 = 1'b1;
        dec.imm      = sext(inst, 4'd6);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: one-entry pipeline register with a register busy scoreboard for RAW stalls.
module id_stage
  import lc3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  decoded_t        dec_in;
  decoded_t        dec_q;
  logic            held;
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;
  logic            hazard;
  logic            accept;
  logic            handoff;

  inst_decoder u_decoder (
    .inst (bus.if_inst),
    .dec  (dec_in)
  );

  // Stall looks only at the registered busy bits, so release lags writeback by one cycle.
  assign hazard  = held && ((dec_q.uses_sr1 && busy[dec_q.sr1]) ||
                            (dec_q.uses_sr2 && busy[dec_q.sr2]));
  assign bus.id_valid = held && !hazard;
  assign bus.if_ready = !rst && !bus.flush && (!held || (bus.id_valid && bus.ex_ready));
  assign accept  = bus.if_valid && bus.if_ready;
  assign handoff = bus.id_valid && bus.ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      held   <= 1'b0;
      dec_q  <= '0;
      inst_q <= '0;
      pc_q   <= '0;
    end else begin
      if (bus.flush) begin
        held <= 1'b0;
      end else if (accept) begin
        held <= 1'b1;
      end else if (handoff) begin
        held <= 1'b0;
      end
      if (accept) begin
        dec_q  <= dec_in;
        inst_q <= bus.if_inst;
        pc_q   <= bus.if_pc;
      end
    end
  end

  // The set is written last so it wins over a same-cycle writeback clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (bus.wb_valid) begin
        busy[bus.wb_dr] <= 1'b0;
      end
      if (handoff && dec_q.writes_dr) begin
        busy[dec_q.dr] <= 1'b1;
      end
    end
  end

  assign bus.inst    = inst_q;
  assign bus.op_type = dec_q.op_type;
  assign bus.SR1     = dec_q.sr1;
  assign bus.SR2     = dec_q.sr2;
  assign bus.DR      = dec_q.dr;
  assign bus.imm     = dec_q.imm;
  assign bus.n       = dec_q.n;
  assign bus.z       = dec_q.z;
  assign bus.p       = dec_q.p;
  assign bus.IP      = pc_q;

endmodule
